// File: rtl/bg_tile_renderer.sv
// Background tile renderer: scrolled tile-map lookup, tile-sheet fetch, one RGB444 pixel per clk.
// Latency 3 + MAP_LAT + SHEET_LAT clk (5 by default); rgb, rgb_valid, hsync_out and vsync_out share it.
// No backpressure: every input is sampled every cycle and the pipe never stalls.
//
// Ports:
//   clk, reset                 pixel clock, asynchronous active-high reset
//   video_on, hsync_in,        raw timing from the sync generator for the pixel at (x, y)
//   vsync_in, x, y
//   bg_x_offset                horizontal scroll in pixels, applied to the very next sampled pixel
//   map_addr / map_data        tile-map RAM port (data valid MAP_LAT cycles after the address)
//   sheet_addr / sheet_data    tile-sheet ROM port (data valid SHEET_LAT cycles after the address)
//   rgb, rgb_valid             output pixel and its active-video qualifier
//   hsync_out, vsync_out       sync delayed to line up with rgb
module bg_tile_renderer #(
  parameter int          TILE_COLS       = 40,
  parameter int          TILE_ROWS       = 30,
  parameter int          MAP_LAT         = 1,
  parameter int          SHEET_LAT       = 1,
  parameter logic [11:0] BG_COLOR        = 12'h6AF,
  parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [3:0]  bg_x_offset,
  output logic [15:0] map_addr,
  input  logic [31:0] map_data,
  output logic [13:0] sheet_addr,
  input  logic [11:0] sheet_data,
  output logic [11:0] rgb,
  output logic        rgb_valid,
  output logic        hsync_out,
  output logic        vsync_out
);

  // Side-band carried from S0 while the map read is in flight.
  typedef struct packed {
    logic       von;
    logic       hs;
    logic       vs;
    logic [3:0] px;
    logic [3:0] py;
  } s0_t;

  // Decoded map entry with flips already applied to the in-tile coordinates.
  typedef struct packed {
    logic       von;
    logic       hs;
    logic       vs;
    logic       en;
    logic [2:0] row;
    logic [2:0] col;
    logic [3:0] px;
    logic [3:0] py;
  } s1_t;

  // Side-band carried while the sheet read is in flight.
  typedef struct packed {
    logic von;
    logic hs;
    logic vs;
    logic en;
  } sb_t;

  // Captured sheet pixel plus its side-band, consumed by the output stage.
  typedef struct packed {
    sb_t        sb;
    logic [11:0] pix;
  } cap_t;

  // Sync shadows reset high (idle level) so no spurious sync pulse walks out after reset.
  localparam s0_t  S0_RST  = '{von: 1'b0, hs: 1'b1, vs: 1'b1, px: 4'd0, py: 4'd0};
  localparam s1_t  S1_RST  = '{von: 1'b0, hs: 1'b1, vs: 1'b1, en: 1'b0,
                               row: 3'd0, col: 3'd0, px: 4'd0, py: 4'd0};
  localparam sb_t  SB_RST  = '{von: 1'b0, hs: 1'b1, vs: 1'b1, en: 1'b0};
  localparam cap_t CAP_RST = '{sb: SB_RST, pix: 12'd0};

  logic [10:0] sx;
  logic [6:0]  tc;
  logic [4:0]  tr;
  logic [15:0] map_addr_d, map_addr_q;
  s0_t         s0_d;
  s0_t         s0_q [MAP_LAT];
  s0_t         s0_m;
  s1_t         s1_d, s1_q;
  logic [13:0] sheet_addr_d, sheet_addr_q;
  sb_t         s2_q [SHEET_LAT];
  cap_t        cap_d, cap_q;
  logic [11:0] rgb_d, rgb_q;
  logic        rgb_valid_q, hsync_out_q, vsync_out_q;

  // Entry bits above the enable are reserved for the engine.
  logic unused_map_bits;
  assign unused_map_bits = ^map_data[31:9];

  // S0: scrolled tile coordinates. sx never exceeds 654, so one subtract is enough to wrap.
  always_comb begin
    sx = 11'(x) + 11'(bg_x_offset);
    tc = sx[10:4];
    if (tc >= 7'(TILE_COLS)) tc = tc - 7'(TILE_COLS);
    tr = y[8:4];
    if (y >= 10'(TILE_ROWS * 16)) tr = 5'd0;
    map_addr_d = 16'(tr) * 16'(TILE_COLS) + 16'(tc);
    s0_d = '{von: video_on, hs: hsync_in, vs: vsync_in, px: sx[3:0], py: y[3:0]};
  end

  // S1: map entry meets the side-band that waited for it. For 4 bits, ~p == 15 - p.
  always_comb begin
    s0_m = s0_q[MAP_LAT-1];
    s1_d = '{von: s0_m.von, hs: s0_m.hs, vs: s0_m.vs, en: map_data[8],
             row: map_data[5:3], col: map_data[2:0],
             px: map_data[6] ? ~s0_m.px : s0_m.px,
             py: map_data[7] ? ~s0_m.py : s0_m.py};
  end

  // S2: 128x128 sheet, 8x8 grid of 16x16 tiles.
  assign sheet_addr_d = {s1_q.row, s1_q.py, s1_q.col, s1_q.px};

  assign cap_d = '{sb: s2_q[SHEET_LAT-1], pix: sheet_data};

  // S3: blanking forces black; disabled tiles and keyed pixels show the background colour.
  always_comb begin
    rgb_d = 12'd0;
    if (cap_q.sb.von) begin
      if (!cap_q.sb.en || cap_q.pix == TRANSPARENT_KEY) rgb_d = BG_COLOR;
      else                                              rgb_d = cap_q.pix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      map_addr_q <= 16'd0;
      for (int i = 0; i < MAP_LAT; i++) s0_q[i] <= S0_RST;
      s1_q         <= S1_RST;
      sheet_addr_q <= 14'd0;
      for (int i = 0; i < SHEET_LAT; i++) s2_q[i] <= SB_RST;
      cap_q        <= CAP_RST;
      rgb_q        <= 12'd0;
      rgb_valid_q  <= 1'b0;
      hsync_out_q  <= 1'b1;
      vsync_out_q  <= 1'b1;
    end else begin
      map_addr_q <= map_addr_d;
      s0_q[0]    <= s0_d;
      for (int i = 1; i < MAP_LAT; i++) s0_q[i] <= s0_q[i-1];
      s1_q         <= s1_d;
      sheet_addr_q <= sheet_addr_d;
      s2_q[0]      <= '{von: s1_q.von, hs: s1_q.hs, vs: s1_q.vs, en: s1_q.en};
      for (int i = 1; i < SHEET_LAT; i++) s2_q[i] <= s2_q[i-1];
      cap_q        <= cap_d;
      rgb_q        <= rgb_d;
      rgb_valid_q  <= cap_q.sb.von;
      hsync_out_q  <= cap_q.sb.hs;
      vsync_out_q  <= cap_q.sb.vs;
    end
  end

  assign map_addr   = map_addr_q;
  assign sheet_addr = sheet_addr_q;
  assign rgb        = rgb_q;
  assign rgb_valid  = rgb_valid_q;
  assign hsync_out  = hsync_out_q;
  assign vsync_out  = vsync_out_q;

endmodule

// File: tb/tb_bg_tile_renderer.sv
// Directed bench for bg_tile_renderer with behavioural tile-map / tile-sheet memories.
module tb_bg_tile_renderer;

  logic        clk;
  logic        reset;
  logic        video_on, hsync_in, vsync_in;
  logic [9:0]  x, y;
  logic [3:0]  bg_x_offset;
  logic [15:0] map_addr;
  logic [31:0] map_data;
  logic [13:0] sheet_addr;
  logic [11:0] sheet_data;
  logic [11:0] rgb;
  logic        rgb_valid, hsync_out, vsync_out;

  bg_tile_renderer dut (
    .clk(clk), .reset(reset), .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .bg_x_offset(bg_x_offset),
    .map_addr(map_addr), .map_data(map_data),
    .sheet_addr(sheet_addr), .sheet_data(sheet_data),
    .rgb(rgb), .rgb_valid(rgb_valid), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 memories: data follows the registered address within the same cycle.
  logic [31:0] map_mem   [0:1199];
  logic [11:0] sheet_mem [0:16383];
  assign map_data   = (map_addr < 16'd1200) ? map_mem[map_addr[10:0]] : 32'h0;
  assign sheet_data = sheet_mem[sheet_addr];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [9:0] xx, input logic [9:0] yy, input logic [3:0] oo,
                     input logic vo, input logic h, input logic v);
    x = xx; y = yy; bg_x_offset = oo; video_on = vo; hsync_in = h; vsync_in = v;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  off;
    logic        von;
    logic        hs;
    logic        vs;
    logic [10:0] mwa;
    logic [31:0] mwd;
    logic [13:0] swa;
    logic [11:0] swd;
    logic [15:0] e_map;
    logic [13:0] e_sheet;
    logic [11:0] e_rgb;
    logic        e_vld;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  logic sv [8];
  logic sh [8];

  initial begin
    // {x, y, off, von, hs, vs, map wr addr, map wr data, sheet wr addr, sheet wr data,
    //  expected map_addr, sheet_addr, rgb, rgb_valid}
    vt[0]  = '{10'd0,   10'd0,   4'd0,  1'b1, 1'b1, 1'b1, 11'd0,    32'h130,      14'd12288, 12'hABC,
               16'd0,    14'd12288, 12'hABC, 1'b1};
    vt[1]  = '{10'd3,   10'd5,   4'd0,  1'b1, 1'b1, 1'b1, 11'd0,    32'h171,      14'd12956, 12'h456,
               16'd0,    14'd12956, 12'h456, 1'b1};
    vt[2]  = '{10'd3,   10'd5,   4'd0,  1'b1, 1'b1, 1'b1, 11'd0,    32'h1F1,      14'd13596, 12'h789,
               16'd0,    14'd13596, 12'h789, 1'b1};
    vt[3]  = '{10'd636, 10'd40,  4'd8,  1'b1, 1'b0, 1'b1, 11'd80,   32'h113,      14'd5172,  12'h321,
               16'd80,   14'd5172,  12'h321, 1'b1};
    vt[4]  = '{10'd80,  10'd0,   4'd0,  1'b1, 1'b1, 1'b1, 11'd5,    32'h013,      14'd4144,  12'h555,
               16'd5,    14'd4144,  12'h6AF, 1'b1};
    vt[5]  = '{10'd96,  10'd16,  4'd0,  1'b1, 1'b1, 1'b0, 11'd46,   32'h10A,      14'd2080,  12'hF0F,
               16'd46,   14'd2080,  12'h6AF, 1'b1};
    vt[6]  = '{10'd17,  10'd33,  4'd0,  1'b1, 1'b1, 1'b1, 11'd81,   32'hFFFFFF1C, 14'd6337,  12'h123,
               16'd81,   14'd6337,  12'h123, 1'b1};
    vt[7]  = '{10'd0,   10'd0,   4'd0,  1'b0, 1'b1, 1'b1, 11'd0,    32'h130,      14'd12288, 12'hABC,
               16'd0,    14'd12288, 12'h000, 1'b0};
    vt[8]  = '{10'd20,  10'd490, 4'd0,  1'b1, 1'b1, 1'b1, 11'd1,    32'h100,      14'd1284,  12'h2B2,
               16'd1,    14'd1284,  12'h2B2, 1'b1};
    vt[9]  = '{10'd639, 10'd479, 4'd15, 1'b1, 1'b1, 1'b1, 11'd1160, 32'h13F,      14'd16382, 12'hFED,
               16'd1160, 14'd16382, 12'hFED, 1'b1};
    vt[10] = '{10'd15,  10'd0,   4'd1,  1'b1, 1'b1, 1'b1, 11'd1,    32'h100,      14'd0,     12'h0F0,
               16'd1,    14'd0,     12'h0F0, 1'b1};

    for (int i = 0; i < 1200; i++) map_mem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) sheet_mem[i] = 12'h0;

    reset = 1'b1;
    drv(10'd0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b1);
    #12;
    chk("reset map_addr",   32'(map_addr),   32'd0);
    chk("reset sheet_addr", 32'(sheet_addr), 32'd0);
    chk("reset rgb",        32'(rgb),        32'd0);
    chk("reset rgb_valid",  32'(rgb_valid),  32'd0);
    chk("reset hsync_out",  32'(hsync_out),  32'd1);
    chk("reset vsync_out",  32'(vsync_out),  32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    // Single pixels separated by blanking, each followed through the whole pipe.
    for (int i = 0; i < NV; i++) begin
      map_mem[vt[i].mwa]   = vt[i].mwd;
      sheet_mem[vt[i].swa] = vt[i].swd;
      drv(vt[i].x, vt[i].y, vt[i].off, vt[i].von, vt[i].hs, vt[i].vs);
      @(posedge clk); #1;
      drv(10'd0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("v%0d map_addr", i), 32'(map_addr), 32'(vt[i].e_map));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("v%0d sheet_addr", i), 32'(sheet_addr), 32'(vt[i].e_sheet));
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("v%0d rgb", i),       32'(rgb),       32'(vt[i].e_rgb));
      chk($sformatf("v%0d rgb_valid", i), 32'(rgb_valid), 32'(vt[i].e_vld));
      chk($sformatf("v%0d hsync_out", i), 32'(hsync_out), 32'(vt[i].hs));
      chk($sformatf("v%0d vsync_out", i), 32'(vsync_out), 32'(vt[i].vs));
    end

    // Back-to-back stream: one blanked pixel and an hsync pulse mid-run.
    map_mem[0] = 32'h130;
    for (int k = 0; k < 8; k++) sheet_mem[12288 + k] = 12'h100 + 12'(k);
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    sh = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 12; j++) begin
      if (j < 8) drv(10'(j), 10'd0, 4'd0, sv[j], sh[j], 1'b1);
      else       drv(10'd0, 10'd0, 4'd0, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      if (j >= 4) begin
        chk($sformatf("stream%0d rgb", j - 4), 32'(rgb),
            sv[j-4] ? 32'h100 + 32'(j - 4) : 32'd0);
        chk($sformatf("stream%0d rgb_valid", j - 4), 32'(rgb_valid), 32'(sv[j-4]));
        chk($sformatf("stream%0d hsync_out", j - 4), 32'(hsync_out), 32'(sh[j-4]));
      end
    end

    // Reset mid-line with a full pipe of visible pixels and hsync low.
    drv(10'd0, 10'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    chk("preload rgb_valid", 32'(rgb_valid), 32'd1);
    chk("preload hsync_out", 32'(hsync_out), 32'd0);
    #2;
    reset = 1'b1;
    hsync_in = 1'b1;
    #1;
    chk("midreset rgb",       32'(rgb),       32'd0);
    chk("midreset rgb_valid", 32'(rgb_valid), 32'd0);
    chk("midreset hsync_out", 32'(hsync_out), 32'd1);
    chk("midreset map_addr",  32'(map_addr),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("release+%0d rgb_valid", c), 32'(rgb_valid), (c == 5) ? 32'd1 : 32'd0);
      chk($sformatf("release+%0d rgb", c),       32'(rgb),       (c == 5) ? 32'h100 : 32'd0);
      chk($sformatf("release+%0d hsync_out", c), 32'(hsync_out), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1);
  end

endmodule
